// File: rtl/led_flow_module.sv
// led_flow_module: prescaled running-light driver for a 4-bit LED bus.
// A prescaler produces step ticks. A mode FSM loads a start pattern through
// INIT and then advances it on each tick: rotate left, rotate right,
// ping-pong, or blink-all.
module led_flow_module #(
    parameter int unsigned STEP_CNT = 12_500_000
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic [1:0] Mode_Sel,
    input  logic       Run_En,
    output logic [3:0] LED_Out,
    output logic       Step_Tick
);

    localparam int unsigned CW = (STEP_CNT > 32'd1) ? $clog2(STEP_CNT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STEP_CNT - 32'd1);

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        SHIFT_L = 2'd1,
        SHIFT_R = 2'd2,
        BLINK   = 2'd3
    } state_t;

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic [3:0]    led_r;
    logic [3:0]    led_s;
    state_t        state_r;
    state_t        state_s;
    logic [1:0]    mode_r;
    logic          mode_chg_s;
    logic          tick_s;

    // Rotate a 4-bit pattern one position toward the MSB.
    function automatic logic [3:0] rot_left(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

    // Rotate a 4-bit pattern one position toward the LSB.
    function automatic logic [3:0] rot_right(input logic [3:0] v);
        return {v[0], v[3:1]};
    endfunction

    assign mode_chg_s = (Mode_Sel != mode_r);
    // A pending mode change wins over a tick; INIT never ticks.
    assign tick_s     = Run_En & (cnt_r == CNT_MAX) & ~mode_chg_s & (state_r != INIT);
    assign Step_Tick  = tick_s;
    assign LED_Out    = led_r;

    // Mode sample register: compared against the live input to detect changes.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            mode_r <= 2'b00;
        end else begin
            mode_r <= Mode_Sel;
        end
    end

    // State, prescaler and LED pattern registers.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cnt_r   <= '0;
            led_r   <= 4'b0001;
            state_r <= INIT;
        end else begin
            cnt_r   <= cnt_s;
            led_r   <= led_s;
            state_r <= state_s;
        end
    end

    // Next-state logic: mode change reload, INIT load, then run/freeze.
    always_comb begin
        cnt_s   = cnt_r;
        led_s   = led_r;
        state_s = state_r;
        if (mode_chg_s) begin
            // Restart through INIT; the pattern is reloaded on the next cycle.
            cnt_s   = '0;
            state_s = INIT;
        end else if (state_r == INIT) begin
            // INIT proceeds even when frozen so a mode change always reloads.
            cnt_s = '0;
            case (mode_r)
                2'b00: begin
                    led_s   = 4'b0001;
                    state_s = SHIFT_L;
                end
                2'b01: begin
                    led_s   = 4'b1000;
                    state_s = SHIFT_R;
                end
                2'b10: begin
                    led_s   = 4'b0001;
                    state_s = SHIFT_L;
                end
                2'b11: begin
                    led_s   = 4'b1111;
                    state_s = BLINK;
                end
                default: begin
                    led_s   = 4'b0001;
                    state_s = SHIFT_L;
                end
            endcase
        end else if (Run_En) begin
            cnt_s = (cnt_r == CNT_MAX) ? '0 : cnt_r + CW'(1);
            if (tick_s) begin
                case (state_r)
                    SHIFT_L: begin
                        if ((mode_r == 2'b10) && (led_r == 4'b1000)) begin
                            led_s   = 4'b0100;
                            state_s = SHIFT_R;
                        end else begin
                            led_s = rot_left(led_r);
                        end
                    end
                    SHIFT_R: begin
                        if ((mode_r == 2'b10) && (led_r == 4'b0001)) begin
                            led_s   = 4'b0010;
                            state_s = SHIFT_L;
                        end else begin
                            led_s = rot_right(led_r);
                        end
                    end
                    BLINK: begin
                        led_s = ~led_r;
                    end
                    default: begin
                        led_s   = 4'b0001;
                        state_s = INIT;
                    end
                endcase
            end else begin
                led_s = led_r;
            end
        end else begin
            // Frozen: counter, pattern and state hold.
            cnt_s   = cnt_r;
            led_s   = led_r;
            state_s = state_r;
        end
    end

endmodule
